// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode/execute issue controller for the 3-bit-register pipeline.
// Keeps a shift register of in-flight destinations (stage 1 = EX ... stage DEPTH = WB),
// detects RAW hazards against the decode sources, stalls or forwards, and counts stalls.
module hazard_scoreboard #(
    parameter int DEPTH  = 3,
    parameter int FWD_EN = 1,
    parameter int SW     = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dec_valid,
    input  logic [2:0]    dec_src1,
    input  logic [2:0]    dec_src2,
    input  logic          dec_use1,
    input  logic          dec_use2,
    input  logic          dec_wb,
    input  logic [2:0]    dec_dst,
    input  logic          dec_mem_read,
    input  logic          flush,
    output logic          stall,
    output logic          issue,
    output logic [SW-1:0] fwd_sel1,
    output logic [SW-1:0] fwd_sel2,
    output logic          wb_en,
    output logic [2:0]    wb_dst,
    output logic          busy,
    output logic [15:0]   stall_count
);

    // Per-stage entry fields, index 1 is the youngest (EX), DEPTH the oldest (WB).
    logic [DEPTH:1] v_q;
    logic [DEPTH:1] wb_q;
    logic [DEPTH:1] ld_q;
    logic [2:0]     dst_q [1:DEPTH];

    logic [DEPTH:1] match1;
    logic [DEPTH:1] match2;
    logic           haz1;
    logic           haz2;

    // Source-versus-destination compare for every tracked stage.
    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            match1[k] = v_q[k] & wb_q[k] & (dst_q[k] == dec_src1);
            match2[k] = v_q[k] & wb_q[k] & (dst_q[k] == dec_src2);
        end
    end

    // Hazard decision: with forwarding only a load still in EX blocks; without it any match does.
    always_comb begin
        haz1 = 1'b0;
        haz2 = 1'b0;
        if (FWD_EN != 0) begin
            haz1 = dec_use1 & match1[1] & ld_q[1];
            haz2 = dec_use2 & match2[1] & ld_q[1];
        end else begin
            haz1 = dec_use1 & (|match1);
            haz2 = dec_use2 & (|match2);
        end
    end

    // Stall/issue; reset gating keeps every output quiet while reset is held.
    always_comb begin
        stall = ~reset & dec_valid & ~flush & (haz1 | haz2);
        issue = ~reset & dec_valid & ~flush & ~stall;
    end

    // Forward select: scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
        fwd_sel1 = '0;
        fwd_sel2 = '0;
        if ((FWD_EN != 0) && !stall && !reset) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (dec_use1 && match1[k]) fwd_sel1 = SW'(k);
                if (dec_use2 && match2[k]) fwd_sel2 = SW'(k);
            end
        end
    end

    // Status views of the table.
    always_comb begin
        busy   = |v_q;
        wb_en  = v_q[DEPTH] & wb_q[DEPTH];
        wb_dst = wb_en ? dst_q[DEPTH] : 3'd0;
    end

    // Pipeline shift: stages never freeze, a stalled or flushed decode inserts a bubble,
    // and a flush also drops the entry leaving stage 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q  <= '0;
            wb_q <= '0;
            ld_q <= '0;
            for (int k = 1; k <= DEPTH; k++) dst_q[k] <= 3'd0;
        end else begin
            for (int k = DEPTH; k >= 3; k--) begin
                v_q[k]   <= v_q[k-1];
                wb_q[k]  <= wb_q[k-1];
                ld_q[k]  <= ld_q[k-1];
                dst_q[k] <= dst_q[k-1];
            end
            if (flush) begin
                v_q[2]   <= 1'b0;
                wb_q[2]  <= 1'b0;
                ld_q[2]  <= 1'b0;
                dst_q[2] <= 3'd0;
            end else begin
                v_q[2]   <= v_q[1];
                wb_q[2]  <= wb_q[1];
                ld_q[2]  <= ld_q[1];
                dst_q[2] <= dst_q[1];
            end
            if (issue) begin
                v_q[1]   <= 1'b1;
                wb_q[1]  <= dec_wb;
                ld_q[1]  <= dec_mem_read;
                dst_q[1] <= dec_dst;
            end else begin
                v_q[1]   <= 1'b0;
                wb_q[1]  <= 1'b0;
                ld_q[1]  <= 1'b0;
                dst_q[1] <= 3'd0;
            end
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= 16'd0;
        end else if (stall && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: one forwarding instance and one non-forwarding instance share stimulus.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       dec_valid, dec_use1, dec_use2, dec_wb, dec_mem_read, flush;
    logic [2:0] dec_src1, dec_src2, dec_dst;

    logic        stall_f, issue_f, wb_en_f, busy_f;
    logic [1:0]  fwd1_f, fwd2_f;
    logic [2:0]  wb_dst_f;
    logic [15:0] cnt_f;

    logic        stall_n, issue_n, wb_en_n, busy_n;
    logic [1:0]  fwd1_n, fwd2_n;
    logic [2:0]  wb_dst_n;
    logic [15:0] cnt_n;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.DEPTH(3), .FWD_EN(1), .SW(2)) u_fwd (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_src1(dec_src1),
        .dec_src2(dec_src2), .dec_use1(dec_use1), .dec_use2(dec_use2), .dec_wb(dec_wb),
        .dec_dst(dec_dst), .dec_mem_read(dec_mem_read), .flush(flush),
        .stall(stall_f), .issue(issue_f), .fwd_sel1(fwd1_f), .fwd_sel2(fwd2_f),
        .wb_en(wb_en_f), .wb_dst(wb_dst_f), .busy(busy_f), .stall_count(cnt_f)
    );

    hazard_scoreboard #(.DEPTH(3), .FWD_EN(0), .SW(2)) u_nofwd (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_src1(dec_src1),
        .dec_src2(dec_src2), .dec_use1(dec_use1), .dec_use2(dec_use2), .dec_wb(dec_wb),
        .dec_dst(dec_dst), .dec_mem_read(dec_mem_read), .flush(flush),
        .stall(stall_n), .issue(issue_n), .fwd_sel1(fwd1_n), .fwd_sel2(fwd2_n),
        .wb_en(wb_en_n), .wb_dst(wb_dst_n), .busy(busy_n), .stall_count(cnt_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s1, input logic u1,
                         input logic [2:0] s2, input logic u2, input logic wb,
                         input logic [2:0] dst, input logic ld);
        dec_valid    = v;
        dec_src1     = s1;
        dec_use1     = u1;
        dec_src2     = s2;
        dec_use2     = u2;
        dec_wb       = wb;
        dec_dst      = dst;
        dec_mem_read = ld;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1);
        tick();
        tick();
        @(negedge clk);
        n_cmp++; if (stall_f !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %0b want 0", stall_f); end
        n_cmp++; if (busy_f !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b want 0", busy_f); end
        n_cmp++; if (cnt_f !== 16'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", cnt_f); end
        n_cmp++; if (fwd1_f !== 2'd0) begin n_err++; $display("FAIL rst_fwd1: got %0d want 0", fwd1_f); end
        n_cmp++; if (wb_en_f !== 1'b0) begin n_err++; $display("FAIL rst_wb_en: got %0b want 0", wb_en_f); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (issue_f !== 1'b1) begin n_err++; $display("FAIL rst_issue: got %0b want 1", issue_f); end
        n_cmp++; if (stall_n !== 1'b0) begin n_err++; $display("FAIL rst_stall_nofwd: got %0b want 0", stall_n); end
        n_cmp++; if (fwd2_f !== 2'd0) begin n_err++; $display("FAIL rst_fwd2: got %0d want 0", fwd2_f); end
        tick();
    endtask

    task automatic test_forwarding();
        do_reset();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0);   // ADD r3
        @(negedge clk);
        n_cmp++; if (issue_f !== 1'b1) begin n_err++; $display("FAIL fwd_add_issue: got %0b want 1", issue_f); end
        tick();
        drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0);   // SUB r1 <- r3
        @(negedge clk);
        n_cmp++; if (stall_f !== 1'b0) begin n_err++; $display("FAIL fwd_sub_stall: got %0b want 0", stall_f); end
        n_cmp++; if (fwd1_f !== 2'd1) begin n_err++; $display("FAIL fwd_sel1_stage1: got %0d want 1", fwd1_f); end
        tick();
        drive(1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0);   // reads r3 on src2
        @(negedge clk);
        n_cmp++; if (fwd2_f !== 2'd2) begin n_err++; $display("FAIL fwd_sel2_stage2: got %0d want 2", fwd2_f); end
        n_cmp++; if (fwd1_f !== 2'd0) begin n_err++; $display("FAIL fwd_sel1_unused: got %0d want 0", fwd1_f); end
        tick();
        drive(1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        n_cmp++; if (fwd1_f !== 2'd3) begin n_err++; $display("FAIL fwd_sel1_stage3: got %0d want 3", fwd1_f); end
        n_cmp++; if (wb_en_f !== 1'b1) begin n_err++; $display("FAIL fwd_wb_en: got %0b want 1", wb_en_f); end
        n_cmp++; if (wb_dst_f !== 3'd3) begin n_err++; $display("FAIL fwd_wb_dst: got %0d want 3", wb_dst_f); end
        tick();
        drive(1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0);   // r3 retired
        @(negedge clk);
        n_cmp++; if (fwd1_f !== 2'd0) begin n_err++; $display("FAIL fwd_retired1: got %0d want 0", fwd1_f); end
        n_cmp++; if (fwd2_f !== 2'd0) begin n_err++; $display("FAIL fwd_retired2: got %0d want 0", fwd2_f); end
        n_cmp++; if (wb_dst_f !== 3'd1) begin n_err++; $display("FAIL fwd_wb_dst_sub: got %0d want 1", wb_dst_f); end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b1);   // LD r5
        tick();
        drive(1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0);   // use r5 on src2
        @(negedge clk);
        n_cmp++; if (stall_f !== 1'b1) begin n_err++; $display("FAIL ld_stall: got %0b want 1", stall_f); end
        n_cmp++; if (issue_f !== 1'b0) begin n_err++; $display("FAIL ld_issue_blocked: got %0b want 0", issue_f); end
        n_cmp++; if (fwd2_f !== 2'd0) begin n_err++; $display("FAIL ld_fwd_during_stall: got %0d want 0", fwd2_f); end
        tick();
        @(negedge clk);
        n_cmp++; if (stall_f !== 1'b0) begin n_err++; $display("FAIL ld_stall_released: got %0b want 0", stall_f); end
        n_cmp++; if (issue_f !== 1'b1) begin n_err++; $display("FAIL ld_issue: got %0b want 1", issue_f); end
        n_cmp++; if (fwd2_f !== 2'd2) begin n_err++; $display("FAIL ld_fwd2: got %0d want 2", fwd2_f); end
        n_cmp++; if (cnt_f !== 16'd1) begin n_err++; $display("FAIL ld_count: got %0d want 1", cnt_f); end
        tick();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
        tick();
        @(negedge clk);
        n_cmp++; if (cnt_f !== 16'd1) begin n_err++; $display("FAIL ld_count_hold: got %0d want 1", cnt_f); end
    endtask

    task automatic test_no_forwarding();
        do_reset();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0);   // write r2
        tick();
        drive(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);   // read r2
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (stall_n !== 1'b1) begin n_err++; $display("FAIL nf_stall cycle %0d: got %0b want 1", i, stall_n); end
            n_cmp++; if (issue_n !== 1'b0) begin n_err++; $display("FAIL nf_issue cycle %0d: got %0b want 0", i, issue_n); end
            n_cmp++; if (busy_n !== 1'b1) begin n_err++; $display("FAIL nf_busy cycle %0d: got %0b want 1", i, busy_n); end
            if (i == 2) begin
                n_cmp++; if (wb_dst_n !== 3'd2) begin n_err++; $display("FAIL nf_wb_dst: got %0d want 2", wb_dst_n); end
            end
            tick();
        end
        @(negedge clk);
        n_cmp++; if (stall_n !== 1'b0) begin n_err++; $display("FAIL nf_stall_end: got %0b want 0", stall_n); end
        n_cmp++; if (issue_n !== 1'b1) begin n_err++; $display("FAIL nf_issue_end: got %0b want 1", issue_n); end
        n_cmp++; if (fwd1_n !== 2'd0) begin n_err++; $display("FAIL nf_fwd1: got %0d want 0", fwd1_n); end
        n_cmp++; if (cnt_n !== 16'd3) begin n_err++; $display("FAIL nf_count: got %0d want 3", cnt_n); end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd4, 1'b0);   // write r4
        tick();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd4, 1'b0);   // write r4 again
        tick();
        drive(1'b1, 3'd4, 1'b1, 3'd4, 1'b1, 1'b0, 3'd0, 1'b0);   // read r4 on both
        @(negedge clk);
        n_cmp++; if (fwd1_f !== 2'd1) begin n_err++; $display("FAIL b2b_youngest1: got %0d want 1", fwd1_f); end
        n_cmp++; if (fwd2_f !== 2'd1) begin n_err++; $display("FAIL b2b_youngest2: got %0d want 1", fwd2_f); end
        n_cmp++; if (stall_f !== 1'b0) begin n_err++; $display("FAIL b2b_stall: got %0b want 0", stall_f); end
        tick();
    endtask

    task automatic test_flush_and_reset();
        do_reset();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd6, 1'b1);   // LD r6
        tick();
        drive(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        n_cmp++; if (stall_f !== 1'b1) begin n_err++; $display("FAIL fl_pre_stall: got %0b want 1", stall_f); end
        flush = 1'b1;
        #1;
        n_cmp++; if (stall_f !== 1'b0) begin n_err++; $display("FAIL fl_stall: got %0b want 0", stall_f); end
        n_cmp++; if (issue_f !== 1'b0) begin n_err++; $display("FAIL fl_issue: got %0b want 0", issue_f); end
        tick();
        flush = 1'b0;
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        n_cmp++; if (busy_f !== 1'b0) begin n_err++; $display("FAIL fl_busy: got %0b want 0", busy_f); end
        n_cmp++; if (cnt_f !== 16'd0) begin n_err++; $display("FAIL fl_count: got %0d want 0", cnt_f); end
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            n_cmp++; if (wb_en_f !== 1'b0) begin n_err++; $display("FAIL fl_wb_en cycle %0d: got %0b want 0", i, wb_en_f); end
        end
        tick();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0);
        tick();
        drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0);
        tick();
        @(negedge clk);
        n_cmp++; if (busy_f !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %0b want 1", busy_f); end
        reset = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++; if (busy_f !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %0b want 0", busy_f); end
        n_cmp++; if (wb_en_f !== 1'b0) begin n_err++; $display("FAIL mid_wb_en: got %0b want 0", wb_en_f); end
        n_cmp++; if (issue_f !== 1'b0) begin n_err++; $display("FAIL mid_issue: got %0b want 0", issue_f); end
        reset = 1'b0;
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
        tick();
        @(negedge clk);
        n_cmp++; if (wb_en_f !== 1'b0) begin n_err++; $display("FAIL mid_wb_en_after: got %0b want 0", wb_en_f); end
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
        test_reset();
        test_forwarding();
        test_load_use();
        test_no_forwarding();
        test_back_to_back();
        test_flush_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
